// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage; returns {remainder, quotient}.
// Optional macro DIV_ZERO_FLAG_EN adds div_zero_o, asserted with ready_o after a divide by zero.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  input  logic                ex_hold_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
`ifdef DIV_ZERO_FLAG_EN
  output logic                div_zero_o,
`endif
  output logic                stall_req_o
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   dvd;      // dividend magnitude, shifts left while quotient bits fill in
  logic [DATA_W-1:0]   dvs;
  logic [DATA_W:0]     rem;
  logic                neg_q, neg_r;
  logic [2*DATA_W-1:0] result;
  logic                ready;

  logic                op1_neg, op2_neg, accept, last_iter;
  logic [DATA_W-1:0]   op1_mag, op2_mag;
  logic [DATA_W:0]     rem_shift, trial, rem_next;
  logic                q_bit;
  logic [DATA_W-1:0]   q_fin, q_fix, r_fix;

  assign accept    = start_i && !annul_i;
  assign last_iter = (cnt == CNT_W'(DATA_W - 1));

  assign op1_neg = signed_div_i && opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i && opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

  // One restoring step: shift in the next dividend bit and keep the trial difference if non-negative.
  assign rem_shift = {rem[DATA_W-1:0], dvd[DATA_W-1]};
  assign trial     = rem_shift - {1'b0, dvs};
  assign q_bit     = ~trial[DATA_W];
  assign rem_next  = q_bit ? trial : rem_shift;
  assign q_fin     = {dvd[DATA_W-2:0], q_bit};
  assign q_fix     = neg_q ? -q_fin : q_fin;
  assign r_fix     = neg_r ? -rem_next[DATA_W-1:0] : rem_next[DATA_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = (opdata2_i == '0) ? S_DIVZERO : S_ON;
      S_DIVZERO: state_next = S_END;
      S_ON:      if (last_iter) state_next = S_END;
      S_END:     if (!ex_hold_i) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (annul_i) state_next = S_IDLE;
  end

  always_comb begin
    stall_req_o = 1'b0;
    case (state)
      S_IDLE:            stall_req_o = accept;
      S_DIVZERO, S_ON:   stall_req_o = 1'b1;
      default:           stall_req_o = 1'b0;
    endcase
  end

`ifdef DIV_ZERO_FLAG_EN
  logic zero_flag;
  always_ff @(posedge clk) begin
    if (!rst)                            zero_flag <= 1'b0;
    else if (annul_i)                    zero_flag <= 1'b0;
    else if (state == S_DIVZERO)         zero_flag <= 1'b1;
    else if (state == S_IDLE && accept)  zero_flag <= 1'b0;
  end
  assign div_zero_o = zero_flag && ready;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= (state_next == S_END);
      if (!annul_i) begin
        case (state)
          S_IDLE: if (start_i) begin
            dvd   <= op1_mag;
            dvs   <= op2_mag;
            neg_q <= op1_neg ^ op2_neg;
            neg_r <= op1_neg;
            rem   <= '0;
            cnt   <= '0;
          end
          S_DIVZERO: result <= '0;
          S_ON: begin
            rem <= rem_next;
            dvd <= q_fin;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) result <= {r_fix, q_fix};
          end
          default: ;
        endcase
      end
    end
  end

  assign result_o = result;
  assign ready_o  = ready;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider in the EX stage. It executes DIV and DIVU.
- Drives the EX stall request (stall_from_ex) into the stall controller while a division is in flight.
- Returns {remainder, quotient} to EX for the HI/LO write-back.
- Cancelled by pipeline flush.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low; acts only at a rising clk edge while low.
- start_i  in  1  EX requests a divide; held by EX until ready_o is seen.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
- opdata1_i  in  DATA_W  dividend; sampled at accept.
- opdata2_i  in  DATA_W  divisor; sampled at accept.
- annul_i  in  1  flush/exception; cancels the operation.
- ex_hold_i  in  1  EX-stage bit of the stall bus; pipeline frozen at EX.
- result_o  out  2*DATA_W  {remainder, quotient}.
- ready_o  out  1  result_o valid.
- stall_req_o  out  1  to stall controller stall_from_ex input.

Behaviour:
- States: IDLE, DIVZERO, ON, END.
- Reset (rst low at edge): state=IDLE, counter=0, result_o=0, ready_o=0, internal dividend/divisor regs=0.
- Reset mid-operation aborts immediately; no partial result ever appears.

IDLE:
- Accept when start_i=1 and annul_i=0.
- If opdata2_i==0 -> DIVZERO, else -> ON.
- At accept: capture operands. When signed_div_i=1, convert negative operands to two's-complement magnitude and record both signs. Clear counter and partial remainder.

DIVZERO:
- One cycle; result register=0 -> END.

ON:
- One quotient bit per cycle, MSB first.
- Partial remainder is DATA_W+1 bits: shift in the next dividend bit, trial-subtract the divisor.
  - Non-negative trial result: keep it, quotient bit=1.
  - Negative trial result: restore, quotient bit=0.
- Counter increments each cycle. After DATA_W iterations, apply sign fix and register the result -> END.
- Sign fix, signed only:
  - Quotient negated if dividend sign differs from divisor sign.
  - Remainder takes the dividend's sign.
- Unsigned: no correction.

END:
- ready_o=1; result_o holds.
- ex_hold_i=1 -> stay in END (result held while pipeline is frozen). Otherwise -> IDLE, ready_o=0 next cycle.

stall_req_o (combinational):
- 1 when (state==IDLE and start_i and !annul_i), or state==DIVZERO, or state==ON.
- 0 in END, so EX consumes the result that cycle.

annul_i:
- annul_i=1 in any state -> IDLE next cycle, ready_o=0, result_o unchanged.
- Overrides ex_hold_i and start_i.

Latency (T = accept cycle):
- Non-zero divisor: ON during T+1..T+DATA_W, END at T+DATA_W+1 (T+33).
- Zero divisor: END at T+2.

Back-to-back:
- END always passes through IDLE, so the next accept is no earlier than END+1.

Boundary case:
- Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. No trap, wraps naturally.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined:
  - Adds output div_zero_o (1 bit). Equals 1 exactly when ready_o=1 and the accepted divisor was 0; otherwise 0. Reset value 0.
  - The flag is registered in DIVZERO and cleared on the next accept, on annul, or on reset.
- Undefined: port absent; divide-by-zero is visible only as result_o=0 at END.

Test Plan:
- Unsigned 7/2, start_i at cycle T -> stall_req_o=1 T..T+32; at T+33 ready_o=1, result_o=0x00000001_00000003, stall_req_o=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> at T+33 result_o=0xFFFFFFFF_FFFFFFFD; signed 7/-2 -> 0x00000001_FFFFFFFD.
- Divisor 0, dividend 0x12345678 -> END at T+2, result_o=0; with DIV_ZERO_FLAG_EN, div_zero_o=1 for that END cycle only.
- annul_i=1 at T+10 -> IDLE at T+11, ready_o never asserts, stall_req_o=0 from T+11. Same outcome for rst low at T+10, plus result_o=0.
- ex_hold_i=1 for 3 cycles starting at the END cycle -> ready_o and result_o stable 3 cycles, then IDLE. Back-to-back divide accepted at END exit+1 gives the correct second result.
- Signed 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000; unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
